// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Streams configuration words LSB-first into a ccff chain and
//               captures the prior chain contents from its tail as readback.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 18,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done
);

    localparam int c_TOT_W = $clog2(CHAIN_LEN + 1);
    localparam int c_BIT_W = $clog2(WORD_W + 1);

    // Terminal counts compared before the increment, so the end of a word
    // or of the chain is known during its final shift cycle.
    localparam logic [c_TOT_W-1:0] c_CHAIN_LAST = c_TOT_W'(CHAIN_LEN - 1);
    localparam logic [c_BIT_W-1:0] c_WORD_LAST  = c_BIT_W'(WORD_W - 1);
    localparam logic [c_TOT_W-1:0] c_TOT_ONE    = c_TOT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE    = c_BIT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WORD_W-1:0]  r_sreg;
    logic [WORD_W-1:0]  r_rb_acc;
    logic [WORD_W-1:0]  r_rb_data;
    logic               r_rb_valid;
    logic [c_TOT_W-1:0] r_tot_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               w_chain_end;
    logic               w_last_bit;
    logic [WORD_W-1:0]  w_rb_capture;

    assign w_chain_end  = (r_tot_cnt == c_CHAIN_LAST);
    assign w_last_bit   = (r_bit_cnt == c_WORD_LAST) || w_chain_end;
    assign w_rb_capture = r_rb_acc | (WORD_W'(ccff_tail) << r_bit_cnt);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control outputs decode the state register only; start and cfg_valid
    // influence nothing but the next state.
    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        ccff_en      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = c_LOAD;
                end
            end
            c_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_state_next = c_SHIFT;
                end
            end
            c_SHIFT: begin
                ccff_en = 1'b1;
                if (w_last_bit) begin
                    w_state_next = w_chain_end ? c_DONE : c_LOAD;
                end
            end
            c_DONE: begin
                done         = 1'b1;
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_sreg     <= '0;
            r_rb_acc   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
            r_tot_cnt  <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_rb_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_tot_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                c_LOAD: begin
                    if (cfg_valid) begin
                        r_sreg    <= cfg_data;
                        r_bit_cnt <= '0;
                        r_rb_acc  <= '0;
                    end
                end
                c_SHIFT: begin
                    r_sreg    <= r_sreg >> 1;
                    r_tot_cnt <= r_tot_cnt + c_TOT_ONE;
                    r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    r_rb_acc  <= w_rb_capture;
                    // Bits beyond a short final word were never captured,
                    // so they read back as zero.
                    if (w_last_bit) begin
                        r_rb_data  <= w_rb_capture;
                        r_rb_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ccff_head = ccff_en & r_sreg[0];
    assign rb_valid  = r_rb_valid;
    assign rb_data   = r_rb_data;

endmodule
`default_nettype wire
